// File: rtl/threshold2_trainer.sv
`default_nettype none
// ============================================================================
// Module   : threshold2_trainer
// Purpose  : Fixed-increment perceptron trainer producing (w1, w2, th) for a
//            2-input threshold gate, with a combinational query port.
// Revision : 1.0 - initial release
// ============================================================================
module threshold2_trainer #(
  parameter int WIDTH      = 16,
  parameter int MAX_EPOCHS = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       target,
  input  logic [WIDTH-1:0] w1_init,
  input  logic [WIDTH-1:0] w2_init,
  input  logic [WIDTH-1:0] th_init,
  output logic [WIDTH-1:0] w1,
  output logic [WIDTH-1:0] w2,
  output logic [WIDTH-1:0] th,
  output logic             busy,
  output logic             done,
  output logic             fail,
  output logic [7:0]       epochs,
  input  logic             qx1,
  input  logic             qx2,
  output logic             qf
);

  localparam logic [2:0] c_IDLE   = 3'd0;
  localparam logic [2:0] c_EVAL   = 3'd1;
  localparam logic [2:0] c_UPDATE = 3'd2;
  localparam logic [2:0] c_CHECK  = 3'd3;
  localparam logic [2:0] c_DONE   = 3'd4;
  localparam logic [2:0] c_FAIL   = 3'd5;

  localparam logic [7:0]              c_MAX_EPOCHS = 8'(MAX_EPOCHS);
  localparam logic signed [WIDTH:0]   c_ONE        = {{WIDTH{1'b0}}, 1'b1};
  localparam logic signed [WIDTH:0]   c_SAT_MAX    = {2'b00, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH:0]   c_SAT_MIN    = {2'b11, {(WIDTH-1){1'b0}}};

  // Sum held in WIDTH+2 bits so w1+w2 can never wrap before the compare.
  function automatic logic gate_f(input logic [WIDTH-1:0] a,
                                  input logic [WIDTH-1:0] b,
                                  input logic [WIDTH-1:0] t,
                                  input logic x1,
                                  input logic x2);
    logic signed [WIDTH+1:0] s;
    logic signed [WIDTH+1:0] te;
    s = '0;
    if (x1) s = s + $signed({{2{a[WIDTH-1]}}, a});
    if (x2) s = s + $signed({{2{b[WIDTH-1]}}, b});
    te = $signed({{2{t[WIDTH-1]}}, t});
    return (s >= te);
  endfunction

  function automatic logic [WIDTH-1:0] sat_step(input logic [WIDTH-1:0] v,
                                                input logic up,
                                                input logic dn);
    logic signed [WIDTH:0] r;
    r = $signed({v[WIDTH-1], v});
    if (up) r = r + c_ONE;
    if (dn) r = r - c_ONE;
    if (r > c_SAT_MAX)      r = c_SAT_MAX;
    else if (r < c_SAT_MIN) r = c_SAT_MIN;
    return r[WIDTH-1:0];
  endfunction

  logic [2:0]       r_state;
  logic [2:0]       w_state_next;
  logic [WIDTH-1:0] r_w1;
  logic [WIDTH-1:0] r_w2;
  logic [WIDTH-1:0] r_th;
  logic [1:0]       r_idx;
  logic [7:0]       r_epochs;
  logic             r_err_seen;
  logic             r_err_pos;
  logic             r_err_neg;
  logic [3:0]       r_target;

  logic             w_x1;
  logic             w_x2;
  logic             w_f;
  logic             w_start_ok;
  logic [7:0]       w_epochs_inc;

  assign w_x1         = r_idx[1];
  assign w_x2         = r_idx[0];
  assign w_f          = gate_f(r_w1, r_w2, r_th, w_x1, w_x2);
  assign w_start_ok   = start && (r_state == c_IDLE || r_state == c_DONE || r_state == c_FAIL);
  assign w_epochs_inc = r_epochs + 8'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= c_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_IDLE, c_DONE, c_FAIL: if (start) w_state_next = c_EVAL;
      c_EVAL:                 w_state_next = c_UPDATE;
      c_UPDATE:               w_state_next = (r_idx == 2'd3) ? c_CHECK : c_EVAL;
      c_CHECK: begin
        if (!r_err_seen)                       w_state_next = c_DONE;
        else if (w_epochs_inc == c_MAX_EPOCHS) w_state_next = c_FAIL;
        else                                   w_state_next = c_EVAL;
      end
      default:                w_state_next = c_IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    fail = 1'b0;
    case (r_state)
      c_EVAL, c_UPDATE, c_CHECK: busy = 1'b1;
      c_DONE:                    done = 1'b1;
      c_FAIL:                    fail = 1'b1;
      default:                   ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_w1       <= '0;
      r_w2       <= '0;
      r_th       <= '0;
      r_idx      <= 2'd0;
      r_epochs   <= 8'd0;
      r_err_seen <= 1'b0;
      r_err_pos  <= 1'b0;
      r_err_neg  <= 1'b0;
      r_target   <= 4'd0;
    end else begin
      if (w_start_ok) begin
        r_w1       <= w1_init;
        r_w2       <= w2_init;
        r_th       <= th_init;
        r_target   <= target;
        r_idx      <= 2'd0;
        r_epochs   <= 8'd0;
        r_err_seen <= 1'b0;
      end
      case (r_state)
        c_EVAL: begin
          // err = target - F: +1 when the gate under-fires, -1 when it over-fires.
          r_err_pos <= r_target[r_idx] & ~w_f;
          r_err_neg <= ~r_target[r_idx] & w_f;
        end
        c_UPDATE: begin
          r_w1 <= sat_step(r_w1, r_err_pos & w_x1, r_err_neg & w_x1);
          r_w2 <= sat_step(r_w2, r_err_pos & w_x2, r_err_neg & w_x2);
          r_th <= sat_step(r_th, r_err_neg, r_err_pos);
          if (r_err_pos || r_err_neg) r_err_seen <= 1'b1;
          if (r_idx != 2'd3)          r_idx      <= r_idx + 2'd1;
        end
        c_CHECK: begin
          r_epochs   <= w_epochs_inc;
          r_idx      <= 2'd0;
          r_err_seen <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign w1     = r_w1;
  assign w2     = r_w2;
  assign th     = r_th;
  assign epochs = r_epochs;
  assign qf     = gate_f(r_w1, r_w2, r_th, qx1, qx2);

endmodule
`default_nettype wire

// File: doc/threshold2_trainer.md
# threshold2_trainer

Sequential perceptron-learning engine for the 2-input threshold gate. Given a 4-entry target truth table and initial weights, it iterates over all input patterns and adjusts w1, w2 and th with the fixed-increment rule until one full epoch is error-free, or until an epoch limit is reached. It is the complement of the threshold2 gate: it produces the (w1, w2, th) that the gate consumes. It also exposes a combinational query port so that learned weights can be checked against the gate function.

## Interface
Parameters:
- WIDTH, 16: width of the signed weight/threshold registers (two's complement).
- MAX_EPOCHS, 16: maximum number of epochs before giving up; ≥1, ≤255.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin training; sampled only in IDLE, DONE or FAIL.
- target  in  4  desired F per pattern, indexed by idx={x1,x2}; target[0] is x1=0,x2=0 and target[3] is x1=1,x2=1.
- w1_init, w2_init, th_init  in  WIDTH each  signed initial values, loaded on start.
- w1, w2, th  out  WIDTH each  signed current weights/threshold, registered.
- busy  out  1  high in EVAL/UPDATE/CHECK.
- done  out  1  level, high in DONE (converged).
- fail  out  1  level, high in FAIL (epoch limit hit).
- epochs  out  8  epochs executed in the current or last run, including the final clean epoch.
- qx1, qx2  in  1 each  query inputs.
- qf  out  1  combinational: (w1·qx1 + w2·qx2 ≥ th) on the current registers.

## Operation
- Gate function: F = 1 iff w1·x1 + w2·x2 ≥ th. Compute the sum signed in WIDTH+2 bits, so it never overflows.
- States:
  - IDLE: busy=0. On start, load w1/w2/th from the init ports, set idx=0, set epochs=0, clear err_seen, go to EVAL.
  - EVAL: x1=idx[1], x2=idx[0]. Compute F and register err = target[idx] − F ∈ {−1, 0, +1}. Go to UPDATE.
  - UPDATE:
    - err=+1: w1+=x1, w2+=x2, th−=1.
    - err=−1: w1−=x1, w2−=x2, th+=1.
    - err≠0: set err_seen.
    - Each result saturates to [−2^(WIDTH−1), 2^(WIDTH−1)−1].
    - idx==3: go to CHECK. Otherwise idx++, go to EVAL.
  - CHECK: epochs++.
    - err_seen=0: go to DONE.
    - Else if epochs (after increment) == MAX_EPOCHS: go to FAIL.
    - Else idx=0, clear err_seen, go to EVAL.
  - DONE / FAIL: terminal; w1/w2/th/epochs are held. start restarts exactly as from IDLE.
- start is ignored while busy. target and the init ports must be stable only at the start edge; target is captured into an internal register on start.
- Reset (any time, including mid-training): state=IDLE, w1=w2=th=0, epochs=0, idx=0, err_seen=0, busy=done=fail=0. qf then reflects 0≥0, i.e. 1.

## Timing
- Each epoch is 9 cycles (4×(EVAL+UPDATE) + CHECK).
- done or fail rises 9·epochs cycles after the clock edge that samples start, and stays high until the next start or reset.
- busy rises on the edge after the start edge and falls on the same edge that done/fail rises.
- Weights change only on UPDATE edges; at most one change per 2 cycles.
- qf has zero latency from qx1/qx2 and from register updates.
- start in DONE/FAIL: done/fail drop on the next edge and busy rises on the same edge.

## Test plan
- OR: target=4'b1110, inits 0/0/0, start → done after 36 cycles; w1=1, w2=1, th=1, epochs=4; qf matches OR for all 4 queries.
- AND: target=4'b1000, inits 0/0/0 → done after 54 cycles; w1=2, w2=1, th=3, epochs=6; qf matches AND.
- XOR: target=4'b0110, MAX_EPOCHS=16 → fail after 144 cycles; done=0, epochs=16, busy=0.
- Saturation (WIDTH=8): target=4'b1111, w1_init=127, w2_init=−128, th_init=127 → after the first epoch, w1=127 (clamped), w2=−126, th=124.
- Reset mid-run: assert rst during the 2nd epoch of the AND case → all outputs go immediately to reset values. A new start with OR then reproduces the OR result exactly.
- Control edges: start pulsed while busy → ignored, result unchanged. start in DONE → clean retrain with new target; reloaded init values are visible one edge after start.
